serdesphy_rx_word_scheduler: RTL and testbench
==============================================

Name: serdesphy_rx_word_scheduler

Overview:
- Sits between the RX 8b decoder output and the RX word disassembler.
- Buffers decoded 8-bit words in a small FIFO and issues them to the disassembler one at a time: single-cycle strobe, gated by the disassembler's ready and a minimum issue spacing.
- Gates traffic on link enable/lock, optionally drops error-flagged words, and keeps overflow/error status for the register block.

Parameters:
- FIFO_DEPTH, 4, buffer entries (power of 2, ≥2)
- ADDR_W, 2, log2(FIFO_DEPTH)
- WORD_SPACING, 4, minimum clk cycles between successive out_valid pulses (≥2); 4 matches the disassembler's 4-cycle word turnaround

Ports:
- clk  in  1  24 MHz clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- rx_enable  in  1  RX path enable
- rx_locked  in  1  CDR/word-align lock
- in_word  in  8  decoded word
- in_valid  in  1  in_word valid, one cycle per word
- in_err  in  1  decode error flag, qualified by in_valid
- drop_err_en  in  1  1 = do not buffer words with in_err
- disasm_ready  in  1  disassembler idle, ready for a word
- clear_status  in  1  one-cycle pulse; clears overflow_sticky and err_count
- out_word  out  8  word to disassembler
- out_valid  out  1  one-cycle issue strobe
- fifo_level  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
- overflow_sticky  out  1  a word was dropped because the FIFO was full
- err_count  out  8  count of in_valid&in_err, saturates at 255
- sched_state  out  2  current FSM state, for debug

Behaviour:
- Reset (async, rst=1) puts the block in this state:
  - state IDLE; FIFO pointers and fifo_level 0.
  - out_word 0x00, out_valid 0.
  - overflow_sticky 0, err_count 0, spacing counter 0.
- active = rx_enable & rx_locked.
- FSM states (sched_state encoding): IDLE=0, RUN=1, ISSUE=2, GAP=3.
  - IDLE: FIFO held flushed and in_valid ignored. When active=1, go to RUN next cycle.
  - RUN: if FIFO non-empty and disasm_ready=1, go to ISSUE.
  - ISSUE: one cycle. out_valid=1, out_word=FIFO head (registered output, so both are valid in the same cycle), and the head is popped this cycle. Load spacing counter with WORD_SPACING-2; go to GAP.
  - GAP: decrement the counter each cycle; when it is 0, go to RUN.
  - Result: consecutive out_valid pulses are ≥ WORD_SPACING cycles apart. Word latency from push into an empty FIFO to out_valid is 2 cycles when disasm_ready=1.
- Leaving active:
  - In any state, active=0 sends the FSM to IDLE next cycle and flushes the FIFO (level 0 next cycle).
  - An out_valid already asserted in the current cycle completes normally; no further pulse follows.
  - Status registers are not cleared by the flush.
- Push: in_valid=1, state≠IDLE, active=1, and not (drop_err_en & in_err).
  - Push when full with no pop in the same cycle: word dropped, FIFO unchanged, overflow_sticky←1.
  - Push and pop in the same cycle: both occur, level unchanged (including when full).
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is computed from an extra pointer MSB, so full and empty are distinct.
- err_count increments on every in_valid&in_err while state≠IDLE, whether or not the word is dropped; it holds at 255.
- clear_status:
  - Clears overflow_sticky and err_count next cycle.
  - If a new overflow or error occurs in the same cycle, the result is sticky=1 and err_count=1.
- disasm_ready is sampled only in RUN; its value in ISSUE/GAP is ignored.
- Words are never reordered or duplicated; FIFO order is preserved.

Test Plan:
- Basic issue: rst, then rx_enable=rx_locked=1, disasm_ready=1, push 0xA5 → out_valid pulse with out_word=0xA5 2 cycles after push; fifo_level returns to 0.
- Burst and spacing: push 0x11,0x22,0x33,0x44 on consecutive cycles → four single-cycle pulses exactly 4 cycles apart, in order; fifo_level peaks at 3.
- Overflow: hold disasm_ready=0 and push 5 words → fifo_level=4, 5th word dropped, overflow_sticky=1. Release ready → only the first 4 words are issued. clear_status → sticky=0.
- Error handling: drop_err_en=1, push 0x5A with in_err=1 → not buffered, err_count=1. With drop_err_en=0, the same stimulus issues 0x5A and err_count=2. Drive 300 error words → err_count stays at 255.
- Lock loss mid-burst: FIFO holding 3 words, drop rx_locked → IDLE next cycle, fifo_level=0, no further out_valid. Relock → RUN, and a new push is issued normally.
- Async reset mid-GAP: assert rst between clk edges → all outputs 0 immediately, sched_state=IDLE; status cleared.

Source files
------------

// File: rtl/serdesphy_rx_word_scheduler.sv
// RX word scheduler: buffers decoded words and issues them to the word
// disassembler as single-cycle strobes with a minimum spacing between words.
module serdesphy_rx_word_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 2,
    parameter int WORD_SPACING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_enable,
    input  logic              rx_locked,
    input  logic [7:0]        in_word,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic              drop_err_en,
    input  logic              disasm_ready,
    input  logic              clear_status,
    output logic [7:0]        out_word,
    output logic              out_valid,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow_sticky,
    output logic [7:0]        err_count,
    output logic [1:0]        sched_state
);

    localparam int CNT_W = (WORD_SPACING > 2) ? $clog2(WORD_SPACING) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(WORD_SPACING - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ISSUE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [7:0]        out_word_q, out_word_d;
    logic              out_valid_q, out_valid_d;
    logic              sticky_q, sticky_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic              active;
    logic [ADDR_W:0]   level;
    logic              empty;
    logic              full;
    logic              flush;
    logic              pop;
    logic              push_req;
    logic              push;
    logic              overflow;
    logic              err_evt;
    logic [7:0]        err_base;

    always_comb begin
        active   = rx_enable & rx_locked;
        level    = wr_ptr_q - rd_ptr_q;
        empty    = (level == '0);
        full     = (level == (ADDR_W+1)'(FIFO_DEPTH));
        flush    = (state_q == IDLE) | ~active;
        pop      = (state_q == ISSUE);
        push_req = in_valid & active & (state_q != IDLE) & ~(drop_err_en & in_err);
        push     = push_req & (~full | pop);
        overflow = push_req & full & ~pop;
        err_evt  = in_valid & in_err & (state_q != IDLE);

        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE:  if (active) state_d = RUN;
            RUN:   if (!empty && disasm_ready) state_d = ISSUE;
            ISSUE: begin
                state_d   = GAP;
                gap_cnt_d = GAP_LOAD;
            end
            GAP: begin
                // Leaving at a count of 1 lets RUN->ISSUE land exactly WORD_SPACING after the last strobe
                if (gap_cnt_q <= CNT_W'(1)) begin
                    state_d   = RUN;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!active) begin
            state_d   = IDLE;
            gap_cnt_d = '0;
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[ADDR_W-1:0]] = in_word;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        end

        out_valid_d = (state_d == ISSUE);
        out_word_d  = out_valid_d ? mem_q[rd_ptr_q[ADDR_W-1:0]] : out_word_q;

        sticky_d = clear_status ? overflow : (sticky_q | overflow);
        err_base = clear_status ? 8'd0 : err_cnt_q;
        err_cnt_d = (err_evt && err_base != 8'hFF) ? err_base + 8'd1 : err_base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_q       <= '{default: '0};
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
            err_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            sticky_q    <= sticky_d;
            err_cnt_q   <= err_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign out_word        = out_word_q;
    assign out_valid       = out_valid_q;
    assign fifo_level      = level;
    assign overflow_sticky = sticky_q;
    assign err_count       = err_cnt_q;
    assign sched_state     = state_q;

endmodule

// File: tb/tb_serdesphy_rx_word_scheduler.sv
// Testbench for serdesphy_rx_word_scheduler: scoreboard of issued words, a
// vector table for fill/overflow/status behaviour, and directed corner cases.
module tb_serdesphy_rx_word_scheduler;

    logic       clk;
    logic       rst;
    logic       rx_enable;
    logic       rx_locked;
    logic [7:0] in_word;
    logic       in_valid;
    logic       in_err;
    logic       drop_err_en;
    logic       disasm_ready;
    logic       clear_status;
    logic [7:0] out_word;
    logic       out_valid;
    logic [2:0] fifo_level;
    logic       overflow_sticky;
    logic [7:0] err_count;
    logic [1:0] sched_state;

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;
    int last_pulse = -1;
    int pulse_cyc[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic       valid;
        logic [7:0] word;
        logic       err;
        logic       drop;
        logic       clr;
        logic       issue;
        int         exp_level;
        int         exp_sticky;
        int         exp_err;
    } vec_t;

    vec_t vecs[9];

    serdesphy_rx_word_scheduler #(
        .FIFO_DEPTH(4),
        .ADDR_W(2),
        .WORD_SPACING(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_enable(rx_enable),
        .rx_locked(rx_locked),
        .in_word(in_word),
        .in_valid(in_valid),
        .in_err(in_err),
        .drop_err_en(drop_err_en),
        .disasm_ready(disasm_ready),
        .clear_status(clear_status),
        .out_word(out_word),
        .out_valid(out_valid),
        .fifo_level(fifo_level),
        .overflow_sticky(overflow_sticky),
        .err_count(err_count),
        .sched_state(sched_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cycle);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one word-slot for a single clock; issue=1 registers the word with the scoreboard
    task automatic applyStimulus(input logic valid, input logic [7:0] word, input logic err,
                                 input logic clr, input logic issue);
        in_valid     = valid;
        in_word      = word;
        in_err       = err;
        clear_status = clr;
        if (issue) exp_q.push_back(word);
        step();
        in_valid     = 1'b0;
        in_err       = 1'b0;
        clear_status = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        checkOutput(name, exp_q.size(), 0);
    endtask

    // Scoreboard: every strobe must match the oldest expected word and respect the spacing
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            pulse_cyc.push_back(cycle);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_pulse: got out_word 0x%0h, expected no strobe at cycle %0d",
                         out_word, cycle);
            end else begin
                checkOutput("scoreboard_word", out_word, exp_q.pop_front());
            end
            if (last_pulse >= 0)
                checkOutput("pulse_spacing_min", int'((cycle - last_pulse) >= 4), 1);
            last_pulse = cycle;
        end
    end

    initial begin
        int peak;
        logic [7:0] burst[4];

        vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0};
        vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 0};
        vecs[2] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 1};
        vecs[3] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, 1};
        vecs[4] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, 1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0, 0};
        vecs[6] = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0, 4, 0, 1};
        vecs[7] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1, 0};
        vecs[8] = '{1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 1'b0, 4, 0, 1};

        rst = 1'b1;
        rx_enable = 1'b0;
        rx_locked = 1'b0;
        in_word = 8'h00;
        in_valid = 1'b0;
        in_err = 1'b0;
        drop_err_en = 1'b0;
        disasm_ready = 1'b0;
        clear_status = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("reset_state", sched_state, 0);
        checkOutput("reset_level", fifo_level, 0);
        checkOutput("reset_out_word", out_word, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_sticky", overflow_sticky, 0);
        checkOutput("reset_err_count", err_count, 0);
        rst = 1'b0;
        step();
        checkOutput("idle_when_inactive", sched_state, 0);

        $display("[TB] basic issue");
        rx_enable = 1'b1;
        rx_locked = 1'b1;
        disasm_ready = 1'b1;
        step();
        checkOutput("enter_run", sched_state, 1);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        checkOutput("basic_no_early_valid", out_valid, 0);
        checkOutput("basic_level_after_push", fifo_level, 1);
        step();
        checkOutput("basic_out_valid", out_valid, 1);
        checkOutput("basic_out_word", out_word, 8'hA5);
        checkOutput("basic_state_issue", sched_state, 2);
        step();
        checkOutput("basic_single_cycle_strobe", out_valid, 0);
        checkOutput("basic_level_drained", fifo_level, 0);
        checkOutput("basic_state_gap", sched_state, 3);

        $display("[TB] burst and spacing");
        repeat (4) step();
        pulse_cyc.delete();
        peak = 0;
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, burst[i], 1'b0, 1'b0, 1'b1);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        waitDrain("burst_drain");
        checkOutput("burst_peak_level", peak, 3);
        checkOutput("burst_pulse_count", pulse_cyc.size(), 4);
        for (int i = 1; i < 4 && i < pulse_cyc.size(); i++)
            checkOutput("burst_exact_spacing", pulse_cyc[i] - pulse_cyc[i-1], 4);

        $display("[TB] overflow and status vectors");
        disasm_ready = 1'b0;
        repeat (6) step();
        checkOutput("table_start_run", sched_state, 1);
        checkOutput("table_start_level", fifo_level, 0);
        for (int i = 0; i < 9; i++) begin
            drop_err_en = vecs[i].drop;
            applyStimulus(vecs[i].valid, vecs[i].word, vecs[i].err, vecs[i].clr, vecs[i].issue);
            checkOutput($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
            checkOutput($sformatf("vec%0d_sticky", i), overflow_sticky, vecs[i].exp_sticky);
            checkOutput($sformatf("vec%0d_err_count", i), err_count, vecs[i].exp_err);
        end
        drop_err_en = 1'b0;
        disasm_ready = 1'b1;
        waitDrain("overflow_drain");
        repeat (6) step();
        checkOutput("overflow_level_empty", fifo_level, 0);

        $display("[TB] error handling");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("err_cleared", err_count, 0);
        drop_err_en = 1'b1;
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        checkOutput("err_drop_count", err_count, 1);
        checkOutput("err_drop_not_buffered", fifo_level, 0);
        drop_err_en = 1'b0;
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        checkOutput("err_keep_count", err_count, 2);
        checkOutput("err_keep_buffered", fifo_level, 1);
        waitDrain("err_keep_drain");
        drop_err_en = 1'b1;
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, i[7:0], 1'b1, 1'b0, 1'b0);
        checkOutput("err_saturate", err_count, 255);
        checkOutput("err_saturate_level", fifo_level, 0);
        drop_err_en = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("err_clear_after_sat", err_count, 0);

        $display("[TB] lock loss mid-burst");
        repeat (6) step();
        disasm_ready = 1'b0;
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        checkOutput("lock_level_before", fifo_level, 3);
        checkOutput("lock_err_before", err_count, 1);
        rx_locked = 1'b0;
        step();
        checkOutput("lock_state_idle", sched_state, 0);
        checkOutput("lock_flushed", fifo_level, 0);
        checkOutput("lock_status_kept", err_count, 1);
        applyStimulus(1'b1, 8'hD1, 1'b1, 1'b0, 1'b0);
        checkOutput("idle_ignores_push", fifo_level, 0);
        checkOutput("idle_ignores_err", err_count, 1);
        disasm_ready = 1'b1;
        repeat (10) step();
        rx_locked = 1'b1;
        step();
        checkOutput("relock_run", sched_state, 1);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        waitDrain("relock_drain");
        step();
        checkOutput("relock_level", fifo_level, 0);

        $display("[TB] async reset mid-gap");
        repeat (6) step();
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        checkOutput("rst_pulse_seen", out_valid, 1);
        step();
        checkOutput("rst_in_gap", sched_state, 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_state", sched_state, 0);
        checkOutput("async_rst_out_word", out_word, 0);
        checkOutput("async_rst_out_valid", out_valid, 0);
        checkOutput("async_rst_level", fifo_level, 0);
        checkOutput("async_rst_sticky", overflow_sticky, 0);
        checkOutput("async_rst_err_count", err_count, 0);
        step();
        rst = 1'b0;
        repeat (3) step();
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
